// File: rtl/console_arbiter_pkg.sv
// Shared console bus types and address map.
// Used by the arbiter, benches and other console bus blocks.
package console_arbiter_pkg;

  localparam logic [31:0] ConsoleCharAddr = 32'h0000_0000;
  localparam logic [31:0] ConsoleCtrlAddr = 32'h0000_0008;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } bus_req_t;

  // Index width for n hosts, never below one bit
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/console_arbiter_rr_pick.sv
// Rotating priority encoder: first request at or after ptr_i.
// Purely combinational; wraps modulo NumHosts.
module console_arbiter_rr_pick
  import console_arbiter_pkg::*;
#(
  parameter int unsigned NumHosts = 2
) (
  input  logic [NumHosts-1:0]           req_i,
  input  logic [idx_width(NumHosts)-1:0] ptr_i,
  output logic [idx_width(NumHosts)-1:0] idx_o,
  output logic                          valid_o
);

  localparam int unsigned IdxW = idx_width(NumHosts);
  localparam int unsigned SumW = IdxW + 1;

  logic [2*NumHosts-1:0] req2;
  logic [NumHosts-1:0]   rot;
  logic [SumW-1:0]       sum;

  // Rotate so bit k of rot is host (ptr_i + k) mod NumHosts
  assign req2 = {req_i, req_i};
  assign rot  = NumHosts'(req2 >> ptr_i);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + SumW'(k);
      end
    end
    if (sum >= SumW'(NumHosts)) begin
      sum = sum - SumW'(NumHosts);
    end
    idx_o = sum[IdxW-1:0];
  end

endmodule

// File: rtl/console_arbiter.sv
// Round-robin console arbiter with burst hold.
// Zero-cycle grant, one-cycle response routing.
module console_arbiter
  import console_arbiter_pkg::*;
#(
  parameter int unsigned NumHosts = 2,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                     ck_i,
  input  logic                     rst_ni,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [4*NumHosts-1:0]    host_be_i,
  input  logic [32*NumHosts-1:0]   host_addr_i,
  input  logic [32*NumHosts-1:0]   host_wd_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [32*NumHosts-1:0]   host_rd_o,
  output logic                     dev_req_o,
  output logic                     dev_we_o,
  output logic [3:0]               dev_be_o,
  output logic [31:0]              dev_addr_o,
  output logic [31:0]              dev_wd_o,
  input  logic                     dev_rvalid_i,
  input  logic [31:0]              dev_rd_i
);

  localparam int unsigned IdxW = idx_width(NumHosts);
  localparam int unsigned CntW = $clog2(MaxBurst + 1);
  localparam int unsigned NPad = 1 << IdxW;
  localparam int unsigned SumW = IdxW + 1;

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] last_host_q, last_host_d;
  logic [IdxW-1:0] resp_owner_q, resp_owner_d;
  logic            last_valid_q, last_valid_d;
  logic            resp_pending_q, resp_pending_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] win_idx;
  logic            pick_valid;
  logic            hold;
  logic            win_valid;
  logic            resp_fire;
  logic [NPad-1:0] req_pad;
  logic [SumW-1:0] ptr_inc;
  logic [IdxW-1:0] ptr_next;

  bus_req_t [NPad-1:0] host_req;
  bus_req_t            win_req;

  console_arbiter_rr_pick #(
    .NumHosts (NumHosts)
  ) u_rr_pick (
    .req_i   (host_req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    host_req = '0;
    for (int h = 0; h < NumHosts; h++) begin
      host_req[h].we   = host_we_i[h];
      host_req[h].be   = host_be_i[4*h +: 4];
      host_req[h].addr = host_addr_i[32*h +: 32];
      host_req[h].wd   = host_wd_i[32*h +: 32];
    end
  end

  // Padding lets last_host/win_idx index without range holes
  assign req_pad = NPad'(host_req_i);

  assign hold = last_valid_q
             && req_pad[last_host_q]
             && (burst_cnt_q < CntW'(MaxBurst));

  // Outputs stay quiet while reset is held
  assign win_valid = rst_ni && (hold || pick_valid);
  assign win_idx   = hold ? last_host_q : pick_idx;
  assign win_req   = win_valid ? host_req[win_idx] : '0;

  assign dev_req_o  = win_valid;
  assign dev_we_o   = win_req.we;
  assign dev_be_o   = win_req.be;
  assign dev_addr_o = win_req.addr;
  assign dev_wd_o   = win_req.wd;

  always_comb begin
    host_gnt_o = '0;
    for (int h = 0; h < NumHosts; h++) begin
      host_gnt_o[h] = win_valid && (win_idx == IdxW'(h));
    end
  end

  assign ptr_inc  = {1'b0, pick_idx} + SumW'(1);
  assign ptr_next = (ptr_inc == SumW'(NumHosts)) ? '0 : ptr_inc[IdxW-1:0];

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    last_host_d    = last_host_q;
    last_valid_d   = 1'b0;
    burst_cnt_d    = '0;
    resp_owner_d   = resp_owner_q;
    resp_pending_d = win_valid;
    if (hold) begin
      last_valid_d = 1'b1;
      burst_cnt_d  = burst_cnt_q + CntW'(1);
    end else if (pick_valid) begin
      last_valid_d = 1'b1;
      last_host_d  = pick_idx;
      burst_cnt_d  = CntW'(1);
      rr_ptr_d     = ptr_next;
    end
    if (win_valid) begin
      resp_owner_d = win_idx;
    end
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      last_host_q    <= '0;
      last_valid_q   <= 1'b0;
      burst_cnt_q    <= '0;
      resp_owner_q   <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      last_host_q    <= last_host_d;
      last_valid_q   <= last_valid_d;
      burst_cnt_q    <= burst_cnt_d;
      resp_owner_q   <= resp_owner_d;
      resp_pending_q <= resp_pending_d;
    end
  end

  // Responses with no grant behind them are dropped
  assign resp_fire = dev_rvalid_i && resp_pending_q;

  always_comb begin
    host_rvalid_o = '0;
    host_rd_o     = '0;
    for (int h = 0; h < NumHosts; h++) begin
      if (resp_fire && (resp_owner_q == IdxW'(h))) begin
        host_rvalid_o[h]        = 1'b1;
        host_rd_o[32*h +: 32] = dev_rd_i;
      end
    end
  end

endmodule

// File: tb/tb_console_arbiter.sv
// Scoreboard bench for console_arbiter.
// Random and directed traffic against a behavioural model.
module tb_console_arbiter;
  import console_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int MB = 4;

  logic              ck_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      host_req_i;
  logic [N-1:0]      host_we_i;
  logic [4*N-1:0]    host_be_i;
  logic [32*N-1:0]   host_addr_i;
  logic [32*N-1:0]   host_wd_i;
  logic [N-1:0]      host_gnt_o;
  logic [N-1:0]      host_rvalid_o;
  logic [32*N-1:0]   host_rd_o;
  logic              dev_req_o;
  logic              dev_we_o;
  logic [3:0]        dev_be_o;
  logic [31:0]       dev_addr_o;
  logic [31:0]       dev_wd_o;
  logic              dev_rvalid_i;
  logic [31:0]       dev_rd_i;

  console_arbiter #(
    .NumHosts (N),
    .MaxBurst (MB)
  ) u_dut (
    .ck_i          (ck_i),
    .rst_ni        (rst_ni),
    .host_req_i    (host_req_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_addr_i   (host_addr_i),
    .host_wd_i     (host_wd_i),
    .host_gnt_o    (host_gnt_o),
    .host_rvalid_o (host_rvalid_o),
    .host_rd_o     (host_rd_o),
    .dev_req_o     (dev_req_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_addr_o    (dev_addr_o),
    .dev_wd_o      (dev_wd_o),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rd_i      (dev_rd_i)
  );

  always #5 ck_i = ~ck_i;

  typedef struct {
    int           cyc;
    logic [N-1:0] gnt;
    logic         req;
    bus_req_t     f;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    int          owner;
    logic [31:0] data;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model: priority pointer, current streak owner/length, response owner
  int       m_ptr   = 0;
  int       m_last  = -1;
  int       m_cnt   = 0;
  int       m_owner = -1;
  bus_req_t fields[N];

  task automatic step(input bit rst, input logic [N-1:0] req,
                      input int rv_mode, input logic [31:0] rd,
                      input int fixed_h, input logic [7:0] ch);
    gnt_exp_t e;
    int       win;
    bit       rv;
    @(posedge ck_i);
    #1;
    cyc++;
    for (int h = 0; h < N; h++) begin
      fields[h].we   = 1'($urandom);
      fields[h].be   = 4'($urandom);
      fields[h].addr = $urandom;
      fields[h].wd   = $urandom;
      if (h == fixed_h) begin
        fields[h].we   = 1'b1;
        fields[h].be   = 4'b0001;
        fields[h].addr = ConsoleCharAddr;
        fields[h].wd   = {24'h0, ch};
      end
      host_we_i[h]          = fields[h].we;
      host_be_i[4*h +: 4]   = fields[h].be;
      host_addr_i[32*h +: 32] = fields[h].addr;
      host_wd_i[32*h +: 32] = fields[h].wd;
    end
    rv = (rv_mode == 1) ? 1'b1 : (rv_mode == 2) ? 1'b0 : (m_owner >= 0);
    rst_ni       = !rst;
    host_req_i   = req;
    dev_rvalid_i = rv;
    dev_rd_i     = rd;
    e.cyc = cyc;
    if (rst) begin
      m_ptr = 0; m_last = -1; m_cnt = 0; m_owner = -1;
      e.gnt = '0; e.req = 1'b0; e.f = '0;
    end else begin
      win = -1;
      if (m_last >= 0 && req[m_last] && m_cnt < MB) begin
        win = m_last;
        m_cnt++;
      end else begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        if (win >= 0) begin
          m_cnt = 1;
          m_ptr = (win + 1) % N;
        end else begin
          m_cnt = 0;
        end
        m_last = win;
      end
      if (rv && m_owner >= 0) rq.push_back('{cyc, m_owner, rd});
      m_owner = win;
      e.gnt = (win >= 0) ? N'(1 << win) : '0;
      e.req = (win >= 0);
      e.f   = (win >= 0) ? fields[win] : '0;
    end
    gq.push_back(e);
    mon_en = 1'b1;
  endtask

  gnt_exp_t        me;
  rsp_exp_t        mr;
  logic [32*N-1:0] erd;

  always @(negedge ck_i) begin
    if (mon_en) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_queue_empty cyc=%0d", cyc);
      end else begin
        me = gq.pop_front();
        if (host_gnt_o !== me.gnt || dev_req_o !== me.req ||
            dev_we_o !== me.f.we || dev_be_o !== me.f.be ||
            dev_addr_o !== me.f.addr || dev_wd_o !== me.f.wd) begin
          errors++;
          $display("FAIL grant cyc=%0d got gnt=%b req=%b we=%b be=%h addr=%h wd=%h want gnt=%b req=%b we=%b be=%h addr=%h wd=%h",
                   me.cyc, host_gnt_o, dev_req_o, dev_we_o, dev_be_o,
                   dev_addr_o, dev_wd_o, me.gnt, me.req, me.f.we,
                   me.f.be, me.f.addr, me.f.wd);
        end
      end
      checks++;
      if (host_rvalid_o !== '0) begin
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL stray_response cyc=%0d got rvalid=%b want none",
                   cyc, host_rvalid_o);
        end else begin
          mr  = rq.pop_front();
          erd = '0;
          erd[32*mr.owner +: 32] = mr.data;
          if (mr.cyc != cyc || host_rvalid_o !== N'(1 << mr.owner) ||
              host_rd_o !== erd) begin
            errors++;
            $display("FAIL response cyc=%0d got rvalid=%b rd=%h want cyc=%0d rvalid=%b rd=%h",
                     cyc, host_rvalid_o, host_rd_o, mr.cyc,
                     N'(1 << mr.owner), erd);
          end
        end
      end else begin
        if (host_rd_o !== '0) begin
          errors++;
          $display("FAIL rd_idle cyc=%0d got rd=%h want 0", cyc, host_rd_o);
        end
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          mr = rq.pop_front();
          errors++;
          $display("FAIL response_missing cyc=%0d got rvalid=0 want owner=%0d data=%h",
                   cyc, mr.owner, mr.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    string s;
    rst_ni       = 1'b1;
    host_req_i   = '0;
    host_we_i    = '0;
    host_be_i    = '0;
    host_addr_i  = '0;
    host_wd_i    = '0;
    dev_rvalid_i = 1'b0;
    dev_rd_i     = '0;
    #2 rst_ni = 1'b0;

    // Reset held with requests toggling
    for (int i = 0; i < 3; i++)
      step(1, N'($urandom), 1, $urandom, -1, 8'h0);
    // Release: hosts 0 and 1 contend
    step(0, 3'b011, 0, $urandom, -1, 8'h0);
    // All requesting: bursts of MB then rotate
    for (int i = 0; i < 14; i++)
      step(0, 3'b111, 0, $urandom, -1, 8'h0);

    // Host 1 streams "ABCDEF" while host 0 wants one slot
    step(0, 3'b000, 0, $urandom, -1, 8'h0);
    s = "ABCDEF";
    step(0, 3'b010, 0, $urandom, 1, s[0]);
    step(0, 3'b011, 0, $urandom, 1, s[1]);
    step(0, 3'b011, 0, $urandom, 1, s[2]);
    step(0, 3'b011, 0, $urandom, 1, s[3]);
    step(0, 3'b011, 0, $urandom, 1, s[4]);
    step(0, 3'b010, 0, $urandom, 1, s[4]);
    step(0, 3'b010, 0, $urandom, 1, s[5]);

    // Pipelined routing to alternating owners
    step(0, 3'b000, 0, $urandom, -1, 8'h0);
    step(0, 3'b001, 0, $urandom, -1, 8'h0);
    step(0, 3'b010, 0, 32'h11, -1, 8'h0);
    step(0, 3'b000, 0, 32'h22, -1, 8'h0);
    // Stray response with nothing outstanding
    step(0, 3'b000, 1, 32'hdead_beef, -1, 8'h0);

    // Reset right after a grant to host 1 (pointer then at 2)
    step(0, 3'b010, 0, $urandom, -1, 8'h0);
    step(1, 3'b111, 1, 32'h55, -1, 8'h0);
    step(0, 3'b111, 0, $urandom, -1, 8'h0);
    step(0, 3'b111, 0, $urandom, -1, 8'h0);

    // Random traffic with occasional strays, drops and resets
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      step(($urandom_range(0, 99) == 0), N'($urandom | $urandom),
           (r == 0) ? 1 : (r == 1) ? 2 : 0, $urandom, -1, 8'h0);
    end

    @(negedge ck_i);
    #1;
    mon_en = 1'b0;
    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got gq=%0d rq=%0d want 0 0",
               gq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_arbiter.md
# console_arbiter

Round-robin bus arbiter that shares the single simulation console device between several bus hosts, such as core data ports, a debug module or a DMA test engine. It sits between the hosts and the console's request/response port. Each cycle it forwards at most one host request and routes the console's next-cycle response back to the host that issued it. An optional burst hold keeps consecutive characters from one host contiguous in the console log.

## Interface
Parameters:
- NumHosts, default 2: number of requesters (≥1).
- MaxBurst, default 4: maximum consecutive grants to one host while it keeps requesting (≥1; 1 = pure round-robin).

Ports:
- ck_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- host_req_i  in  NumHosts  per-host request.
- host_we_i  in  NumHosts  per-host write enable.
- host_be_i  in  NumHosts×4  per-host byte enables; host h uses bits [4h+3:4h].
- host_addr_i  in  NumHosts×32  per-host address.
- host_wd_i  in  NumHosts×32  per-host write data.
- host_gnt_o  out  NumHosts  one-hot grant, combinational, same cycle as the request.
- host_rvalid_o  out  NumHosts  per-host response valid, one-hot or zero.
- host_rd_o  out  NumHosts×32  per-host read data; zero for hosts not receiving a response.
- dev_req_o  out  1  request to the console.
- dev_we_o, dev_be_o, dev_addr_o, dev_wd_o  out  1/4/32/32  fields of the granted host; all zero when dev_req_o=0.
- dev_rvalid_i  in  1  console response valid, one cycle after the request.
- dev_rd_i  in  32  console read data.

## Operation
- State: rr_ptr (index of the host with highest priority next), last_host (winner of the previous cycle), last_valid, burst_cnt (0..MaxBurst), resp_owner, resp_pending.
- Arbitration, one cycle per decision:
  - If last_valid, host_req_i[last_host]=1 and burst_cnt<MaxBurst, then last_host wins again (hold) and burst_cnt increments.
  - Otherwise the first requesting host found scanning rr_ptr, rr_ptr+1, … (mod NumHosts) wins. burst_cnt←1 and rr_ptr←winner+1 mod NumHosts (wraps NumHosts-1→0).
  - No requests: no grant, last_valid←0, burst_cnt←0, rr_ptr unchanged.
- Winner fields are muxed to dev_*, and dev_req_o=1. Grants are never given to non-requesting hosts.
- On a grant, resp_owner←winner and resp_pending←1. With no grant, resp_pending←0.
- Response routing: when dev_rvalid_i=1 and resp_pending=1, host_rvalid_o[resp_owner]=1 and host_rd_o[resp_owner]=dev_rd_i. When dev_rvalid_i=1 and resp_pending=0, the response is dropped and no host output is asserted.
- Hosts are not stalled across cycles. An ungranted host must hold its request, and is guaranteed a grant within (NumHosts-1)×MaxBurst+1 cycles.

## Timing
- Grant and dev_* are combinational from host_req_i and registered state: zero-cycle arbitration.
- Response latency is 1 cycle. A request granted in cycle T gets host_rvalid_o in cycle T+1. Back-to-back grants to different hosts pipeline without bubbles: the T+1 response goes to the T owner while the T+1 grant goes to a new owner.
- Reset values: rr_ptr=0, last_valid=0, burst_cnt=0, resp_pending=0. Hence host_rvalid_o=0, host_rd_o=0, and with no requests dev_req_o=0 and host_gnt_o=0.
- Reset mid-operation: a pending response is discarded; the first post-reset cycle arbitrates from host 0.
- Simultaneous events:
  - A burst expiring while other hosts request: rotation happens in that cycle.
  - A burst expiring with no other requester: the same host is re-granted as a fresh round-robin win, so burst_cnt←1.
- Widths: rr_ptr, last_host and resp_owner are $clog2(NumHosts) bits, minimum 1. burst_cnt is $clog2(MaxBurst+1) bits.

## Structure
- Shared bus package holds the request-field struct (we, be[3:0], addr[31:0], wd[31:0]) and the console address constants (character output 0x0, simulation control 0x8), so benches and other bus blocks share them.
- One natural sub-module, rr_pick: a combinational rotating priority encoder taking req vector and rr_ptr and returning the winner index and a valid flag. The burst/hold logic, registers and muxing stay in console_arbiter.

## Test plan
- Reset: rst_ni low, with host requests toggling → all host_gnt_o, host_rvalid_o, host_rd_o and dev_req_o stay 0. After release, hosts 0 and 1 both request → host 0 is granted first.
- Fairness: NumHosts=3, MaxBurst=1, all hosts requesting continuously → grant sequence 0,1,2,0,1,2. Each host_rvalid_o appears exactly one cycle after its grant with dev_rd_i=0.
- Burst: MaxBurst=4, host 1 writes chars "ABCDEF" continuously while host 0 also requests → host 1 gets 4 grants, host 0 gets 1, then host 1 gets 2. dev_wd_o[7:0] order is 'A','B','C','D',h0-char,'E','F'.
- Pipelined routing: host 0 granted at T, host 1 at T+1, device returns 0x11 then 0x22 → host_rvalid_o[0] with 0x11 at T+1, host_rvalid_o[1] with 0x22 at T+2, no cross-delivery.
- Stray response: dev_rvalid_i=1 with no grant in the prior cycle → no host_rvalid_o asserted.
- Mid-operation reset: assert rst_ni low in the cycle after a grant → no response is delivered, and host 0 wins first after release even though rr_ptr was 2.
